// File: rtl/bp_fe_pkg.sv
// rtl/bp_fe_pkg.sv - front-end shared types and constants
// Provides the BTB update record and the default update-queue depth.
package bp_fe_pkg;

    localparam int rv64_eaddr_width_gp  = 64;
    localparam int bp_fe_btb_upd_els_gp = 4;

    // One pending BTB write: branch site and its resolved target.
    typedef struct packed {
        logic [rv64_eaddr_width_gp-1:0] addr;
        logic [rv64_eaddr_width_gp-1:0] tgt;
    } bp_fe_btb_update_s;

endpackage

// File: rtl/bsg_encode_one_hot.sv
// rtl/bsg_encode_one_hot.sv - one-hot vector to binary index encoder
// Ports:
//   i      : one-hot (or all-zero) input vector
//   addr_o : index of the set bit (0 when none set)
//   v_o    : any bit set
module bsg_encode_one_hot #(
    parameter  int width_p     = 4,
    localparam int lg_width_lp = (width_p > 1) ? $clog2(width_p) : 1
) (
    input  logic [width_p-1:0]     i,
    output logic [lg_width_lp-1:0] addr_o,
    output logic                   v_o
);

    // OR-ing indices is exact for one-hot input and needs no priority chain.
    always_comb begin
        addr_o = '0;
        for (int k = 0; k < width_p; k++) begin
            if (i[k]) begin
                addr_o = addr_o | lg_width_lp'(k);
            end
        end
    end

    assign v_o = |i;

endmodule

// File: rtl/bp_fe_btb_update_queue.sv
// rtl/bp_fe_btb_update_queue.sv - coalescing buffer feeding the front-end BTB write port
// Holds resolved {site, target} updates and writes them into the BTB on cycles
// where fetch is not reading it, unless the queue is full or the head has
// waited starve_limit_p deferred cycles.
// Ports:
//   clk_i, reset_i           : clock, synchronous active-high reset
//   upd_v_i / upd_ready_o    : update handshake from the backend
//   upd_addr_i, upd_tgt_i    : update payload
//   fe_r_v_i                 : fetch is reading the BTB this cycle
//   btb_w_v_o                : BTB write strobe (combinational on fe_r_v_i)
//   btb_w_addr_o, btb_tgt_o  : head entry payload for the BTB write
module bp_fe_btb_update_queue
    import bp_fe_pkg::*;
#(
    parameter  int els_p          = bp_fe_btb_upd_els_gp,
    parameter  int starve_limit_p = 8,
    localparam int eaddr_width_lp = rv64_eaddr_width_gp
) (
    input  logic                      clk_i,
    input  logic                      reset_i,

    input  logic                      upd_v_i,
    output logic                      upd_ready_o,
    input  logic [eaddr_width_lp-1:0] upd_addr_i,
    input  logic [eaddr_width_lp-1:0] upd_tgt_i,

    input  logic                      fe_r_v_i,

    output logic                      btb_w_v_o,
    output logic [eaddr_width_lp-1:0] btb_w_addr_o,
    output logic [eaddr_width_lp-1:0] btb_tgt_o
);

    localparam int ptr_w_lp = $clog2(els_p);
    localparam int cnt_w_lp = $clog2(els_p + 1);
    localparam int stv_w_lp = $clog2(starve_limit_p + 1);

    bp_fe_btb_update_s   mem_q [els_p];
    bp_fe_btb_update_s   mem_d [els_p];
    logic [ptr_w_lp-1:0] head_q, head_d;
    logic [ptr_w_lp-1:0] tail_q, tail_d;
    logic [cnt_w_lp-1:0] count_q, count_d;
    logic [stv_w_lp-1:0] starve_q, starve_d;

    logic                empty, full, starve_hit;
    logic                drain, accept, coalesce, enq_new;
    logic [els_p-1:0]    slot_v;
    logic [els_p-1:0]    match_v;
    logic [ptr_w_lp-1:0] match_idx;
    logic                match_any;

    // Distance of slot i from the head; the slot is occupied when that
    // distance is below the occupancy count.
    function automatic logic [ptr_w_lp-1:0] slot_off(input int idx,
                                                     input logic [ptr_w_lp-1:0] head);
        return ptr_w_lp'(idx) - head;
    endfunction

    assign empty       = (count_q == '0);
    assign full        = (count_q == cnt_w_lp'(els_p));
    assign starve_hit  = (starve_q == stv_w_lp'(starve_limit_p));

    // Ready ignores the same-cycle drain so fe_r_v_i never reaches it.
    assign upd_ready_o = ~full & ~reset_i;
    assign accept      = upd_v_i & upd_ready_o;

    assign drain        = ~reset_i & ~empty & (~fe_r_v_i | full | starve_hit);
    assign btb_w_v_o    = drain;
    assign btb_w_addr_o = mem_q[head_q].addr;
    assign btb_tgt_o    = mem_q[head_q].tgt;

    always_comb begin
        slot_v  = '0;
        match_v = '0;
        for (int i = 0; i < els_p; i++) begin
            slot_v[i]  = (cnt_w_lp'(slot_off(i, head_q)) < count_q);
            match_v[i] = slot_v[i] & (mem_q[i].addr == upd_addr_i);
        end
    end

    bsg_encode_one_hot #(
        .width_p (els_p)
    ) match_enc (
        .i      (match_v),
        .addr_o (match_idx),
        .v_o    (match_any)
    );

    // A head that is leaving this cycle cannot absorb the update; allocate a
    // fresh entry so the newer target is written after the old one.
    assign coalesce = accept & match_any & ~(drain & (match_idx == head_q));
    assign enq_new  = accept & ~coalesce;

    always_comb begin
        mem_d = mem_q;
        if (coalesce) begin
            mem_d[match_idx].tgt = upd_tgt_i;
        end
        if (enq_new) begin
            mem_d[tail_q] = '{addr: upd_addr_i, tgt: upd_tgt_i};
        end

        head_d  = drain   ? head_q + ptr_w_lp'(1) : head_q;
        tail_d  = enq_new ? tail_q + ptr_w_lp'(1) : tail_q;
        count_d = count_q + cnt_w_lp'(enq_new) - cnt_w_lp'(drain);

        starve_d = starve_q;
        if (empty | drain) begin
            starve_d = '0;
        end else if (fe_r_v_i & ~starve_hit) begin
            starve_d = starve_q + stv_w_lp'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            head_q   <= '0;
            tail_q   <= '0;
            count_q  <= '0;
            starve_q <= '0;
        end else begin
            head_q   <= head_d;
            tail_q   <= tail_d;
            count_q  <= count_d;
            starve_q <= starve_d;
        end
    end

    // Payloads carry no reset; occupancy alone decides what is valid.
    always_ff @(posedge clk_i) begin
        mem_q <= mem_d;
    end

endmodule

// File: tb/tb_bp_fe_btb_update_queue.sv
// tb/tb_bp_fe_btb_update_queue.sv - self-checking bench for bp_fe_btb_update_queue
module tb_bp_fe_btb_update_queue;
    import bp_fe_pkg::*;

    localparam int ELS = 4;
    localparam int LIM = 8;

    logic        clk_i = 1'b0;
    logic        reset_i = 1'b1;
    logic        upd_v_i = 1'b0;
    logic        upd_ready_o;
    logic [63:0] upd_addr_i = '0;
    logic [63:0] upd_tgt_i = '0;
    logic        fe_r_v_i = 1'b0;
    logic        btb_w_v_o;
    logic [63:0] btb_w_addr_o;
    logic [63:0] btb_tgt_o;

    bp_fe_btb_update_queue #(
        .els_p          (ELS),
        .starve_limit_p (LIM)
    ) dut (
        .clk_i        (clk_i),
        .reset_i      (reset_i),
        .upd_v_i      (upd_v_i),
        .upd_ready_o  (upd_ready_o),
        .upd_addr_i   (upd_addr_i),
        .upd_tgt_i    (upd_tgt_i),
        .fe_r_v_i     (fe_r_v_i),
        .btb_w_v_o    (btb_w_v_o),
        .btb_w_addr_o (btb_w_addr_o),
        .btb_tgt_o    (btb_tgt_o)
    );

    always #5 clk_i = ~clk_i;

    int total = 0;
    int bad   = 0;

    // Reference model state and scoreboard of expected BTB writes.
    bp_fe_btb_update_s mq[$];
    bp_fe_btb_update_s sb[$];
    int                m_starve = 0;

    // Values sampled in the most recent step.
    logic        s_rdy, s_wv;
    logic [63:0] s_addr, s_tgt;

    typedef struct {
        bit          rst;
        bit          v;
        logic [63:0] a;
        logic [63:0] t;
        bit          fe;
        bit          e_rdy;
        bit          e_wv;
        logic [63:0] e_a;
        logic [63:0] e_t;
        int          e_cnt;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(bit rst, bit v, logic [63:0] a, logic [63:0] t, bit fe,
                                bit e_rdy, bit e_wv, logic [63:0] e_a, logic [63:0] e_t,
                                int e_cnt);
        vec_t r;
        r.rst = rst; r.v = v; r.a = a; r.t = t; r.fe = fe;
        r.e_rdy = e_rdy; r.e_wv = e_wv; r.e_a = e_a; r.e_t = e_t; r.e_cnt = e_cnt;
        return r;
    endfunction

    // One clock: drive at negedge, sample before posedge, advance model after posedge.
    task automatic step(input bit rst, input bit v, input logic [63:0] a,
                        input logic [63:0] t, input bit fe);
        bit m_full, m_rdy, m_drain, was_empty, found;
        bp_fe_btb_update_s e;
        @(negedge clk_i);
        reset_i = rst; upd_v_i = v; upd_addr_i = a; upd_tgt_i = t; fe_r_v_i = fe;
        #4;
        s_rdy = upd_ready_o; s_wv = btb_w_v_o; s_addr = btb_w_addr_o; s_tgt = btb_tgt_o;

        m_full  = (mq.size() == ELS);
        m_rdy   = !rst && !m_full;
        m_drain = !rst && (mq.size() > 0) && (!fe || m_full || m_starve == LIM);
        if (m_drain) sb.push_back(mq[0]);

        chk("model_ready", {63'b0, s_rdy}, {63'b0, m_rdy});
        chk("model_w_v", {63'b0, s_wv}, {63'b0, m_drain});
        if (s_wv === 1'b1) begin
            if (sb.size() == 0) begin
                total++; bad++;
                $display("FAIL sb_unexpected_write: got addr %0h expected no write", s_addr);
            end else begin
                e = sb.pop_front();
                chk("sb_addr", s_addr, e.addr);
                chk("sb_tgt", s_tgt, e.tgt);
            end
        end

        if (rst) begin
            mq.delete();
            m_starve = 0;
        end else begin
            was_empty = (mq.size() == 0);
            if (m_drain) void'(mq.pop_front());
            if (v && m_rdy) begin
                found = 0;
                foreach (mq[i]) if (mq[i].addr == a) begin mq[i].tgt = t; found = 1; end
                if (!found) mq.push_back('{addr: a, tgt: t});
            end
            if (was_empty || m_drain) m_starve = 0;
            else if (fe && m_starve < LIM) m_starve++;
        end

        @(posedge clk_i);
        #1;
        chk("model_count", 64'(dut.count_q), 64'(mq.size()));
    endtask

    initial begin
        // Idle drain
        vecs.push_back(mk(1, 0, 0, 0, 0,                          0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 64'h8000_0010, 64'h8000_0100, 0,  1, 0, 0, 0, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0,                          1, 1, 64'h8000_0010, 64'h8000_0100, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0,                          1, 0, 0, 0, 0));
        // Full and backpressure
        vecs.push_back(mk(0, 1, 64'h10, 64'h110, 1,               1, 0, 0, 0, 1));
        vecs.push_back(mk(0, 1, 64'h20, 64'h120, 1,               1, 0, 0, 0, 2));
        vecs.push_back(mk(0, 1, 64'h30, 64'h130, 1,               1, 0, 0, 0, 3));
        vecs.push_back(mk(0, 1, 64'h40, 64'h140, 1,               1, 0, 0, 0, 4));
        vecs.push_back(mk(0, 1, 64'h50, 64'h150, 1,               0, 1, 64'h10, 64'h110, 3));
        vecs.push_back(mk(0, 1, 64'h50, 64'h150, 1,               1, 0, 0, 0, 4));
        vecs.push_back(mk(0, 0, 0, 0, 0,                          0, 1, 64'h20, 64'h120, 3));
        vecs.push_back(mk(0, 0, 0, 0, 0,                          1, 1, 64'h30, 64'h130, 2));
        vecs.push_back(mk(0, 0, 0, 0, 0,                          1, 1, 64'h40, 64'h140, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0,                          1, 1, 64'h50, 64'h150, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0,                          1, 0, 0, 0, 0));
        // Coalesce
        vecs.push_back(mk(0, 1, 64'h20, 64'hA, 1,                 1, 0, 0, 0, 1));
        vecs.push_back(mk(0, 1, 64'h30, 64'hB, 1,                 1, 0, 0, 0, 2));
        vecs.push_back(mk(0, 1, 64'h20, 64'hC, 1,                 1, 0, 0, 0, 2));
        vecs.push_back(mk(0, 0, 0, 0, 0,                          1, 1, 64'h20, 64'hC, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0,                          1, 1, 64'h30, 64'hB, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0,                          1, 0, 0, 0, 0));
        // Head race
        vecs.push_back(mk(0, 1, 64'h20, 64'hA, 1,                 1, 0, 0, 0, 1));
        vecs.push_back(mk(0, 1, 64'h20, 64'hD, 0,                 1, 1, 64'h20, 64'hA, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0,                          1, 1, 64'h20, 64'hD, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0,                          1, 0, 0, 0, 0));
        // Reset mid-operation
        vecs.push_back(mk(0, 1, 64'h100, 64'h1100, 1,             1, 0, 0, 0, 1));
        vecs.push_back(mk(0, 1, 64'h200, 64'h1200, 1,             1, 0, 0, 0, 2));
        vecs.push_back(mk(0, 1, 64'h300, 64'h1300, 1,             1, 0, 0, 0, 3));
        vecs.push_back(mk(1, 1, 64'h999, 64'h1999, 0,             0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0,                          1, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 64'h400, 64'h440, 0,              1, 0, 0, 0, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0,                          1, 1, 64'h400, 64'h440, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0,                          1, 0, 0, 0, 0));

        foreach (vecs[i]) begin
            step(vecs[i].rst, vecs[i].v, vecs[i].a, vecs[i].t, vecs[i].fe);
            chk($sformatf("vec%0d_ready", i), {63'b0, s_rdy}, {63'b0, vecs[i].e_rdy});
            chk($sformatf("vec%0d_w_v", i), {63'b0, s_wv}, {63'b0, vecs[i].e_wv});
            if (vecs[i].e_wv) begin
                chk($sformatf("vec%0d_w_addr", i), s_addr, vecs[i].e_a);
                chk($sformatf("vec%0d_w_tgt", i), s_tgt, vecs[i].e_t);
            end
            chk($sformatf("vec%0d_count", i), 64'(dut.count_q), 64'(vecs[i].e_cnt));
        end

        // Starvation: fetch reads every cycle, head forced out on the 9th cycle.
        step(0, 1, 64'h1000, 64'h2000, 1);
        chk("starve_enq_w_v", {63'b0, s_wv}, 64'd0);
        for (int k = 1; k <= LIM; k++) begin
            step(0, 0, 0, 0, 1);
            chk($sformatf("starve_defer%0d", k), {63'b0, s_wv}, 64'd0);
        end
        step(0, 0, 0, 0, 1);
        chk("starve_forced_w_v", {63'b0, s_wv}, 64'd1);
        chk("starve_forced_addr", s_addr, 64'h1000);
        chk("starve_forced_tgt", s_tgt, 64'h2000);
        chk("starve_cleared", 64'(dut.starve_q), 64'd0);
        chk("starve_empty", 64'(dut.count_q), 64'd0);

        // Random traffic over a small address set to exercise coalescing.
        for (int n = 0; n < 400; n++) begin
            step($urandom_range(0, 99) == 0,
                 $urandom_range(0, 3) != 0,
                 64'($urandom_range(1, 5)) << 4,
                 64'($urandom),
                 $urandom_range(0, 3) != 0);
        end
        for (int n = 0; n < 2 * ELS; n++) step(0, 0, 0, 0, 0);
        chk("sb_drained", 64'(sb.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bp_fe_btb_update_queue.md
# bp_fe_btb_update_queue

Small buffer between backend branch-resolution updates and the write port of the front-end BTB. The BTB gives writes priority over reads, so every write destroys a same-cycle prediction lookup. This block holds pending {branch site, target} updates and drains them into the BTB only when the fetch path is not issuing a BTB read, or when a full queue or starvation limit forces it. Updates to an address already queued are coalesced in place.

## Interface
- `els_p`, default 4: queue depth in entries. Power of two, ≥2.
- `starve_limit_p`, default 8: number of consecutive deferred-drain cycles before a write is forced.
- `eaddr_width_lp`, localparam = `rv64_eaddr_width_gp` (64): address and target width.
- `clk_i  in  1  clock`: one clock domain. Reset is synchronous and active-high.
- `reset_i  in  1  synchronous active-high reset`.
- `upd_v_i  in  1  update valid`: backend presents a resolved taken branch.
- `upd_ready_o  out  1  update accepted`: the handshake completes when `upd_v_i & upd_ready_o` is high.
- `upd_addr_i  in  eaddr_width_lp  branch site address`.
- `upd_tgt_i  in  eaddr_width_lp  branch target`.
- `fe_r_v_i  in  1  BTB read request`: fetch intends a BTB read this cycle.
- `btb_w_v_o  out  1  BTB write valid`: connects to the BTB `w_v_i`.
- `btb_w_addr_o  out  eaddr_width_lp  BTB write site`: connects to `w_addr_i`.
- `btb_tgt_o  out  eaddr_width_lp  BTB write target`: connects to `br_tgt_i`.

## Operation
- **Storage:** circular buffer of `els_p` entries, each holding {addr, tgt}.
- **Pointers and count:** head pointer, tail pointer, and an occupancy count of width `$clog2(els_p+1)`. Both pointers wrap modulo `els_p`.
- **Status:** `empty` = (count==0); `full` = (count==els_p).
- **Ready:** `upd_ready_o = ~full & ~reset_i`. This is independent of same-cycle dequeue, so there is no combinational path from `fe_r_v_i` to ready.
- **Drain:**
  - `drain = ~empty & (~fe_r_v_i | full | starve_hit)`.
  - `btb_w_v_o = drain`.
  - `btb_w_addr_o` and `btb_tgt_o` always present the head entry. They are don't-care when `btb_w_v_o` is 0; the bench checks them only when valid.
- **Starve counter:**
  - Increments on each cycle with `~empty & fe_r_v_i & ~drain`.
  - Clears on any drain, and clears when empty.
  - Saturates at `starve_limit_p`.
  - `starve_hit` = (counter == `starve_limit_p`).
- **Coalescing:** an accepted update whose `upd_addr_i` equals the addr of a valid entry overwrites that entry's tgt. Pointers and count do not change.
  - Exception: if the only match is the head and `drain` is high this cycle, the update allocates a new entry instead. The BTB then receives both writes in order, and the newest target wins.
  - At most one entry can match, because coalescing keeps addresses unique.
- **Enqueue without a match:** write the entry at the tail, then tail+1.
- **Simultaneous enqueue and drain:** count is unchanged and both pointers advance.
- **Ordering:** distinct addresses drain in acceptance order.
- **Reset:**
  - count, head, tail and the starve counter go to 0.
  - `btb_w_v_o` = 0 and `upd_ready_o` = 0 while `reset_i` is high.
  - Reset mid-operation discards all pending entries without writing them. This is acceptable because the BTB is a hint.
  - Entry payloads are not reset.

## Timing
- **Enqueue to write:** an update accepted in cycle N can first appear as `btb_w_v_o` in cycle N+1. There is no same-cycle bypass.
- **Combinational path:** `btb_w_v_o` depends combinationally on `fe_r_v_i`. Fetch must drive `fe_r_v_i` early in the cycle.
- **Throughput:** one accept per cycle and one drain per cycle.
- **Worst-case write latency:** while `fe_r_v_i` is continuously high, the head is written within `starve_limit_p`+1 cycles of becoming head.
- **Refill:** full, with `upd_v_i` held high. The forced drain occurs this cycle, and `upd_ready_o` rises the next cycle.
- **First cycle after reset deasserts:** `upd_ready_o` = 1 and `btb_w_v_o` = 0.

## Structure
- `bp_fe_pkg` gets:
  - typedef `bp_fe_btb_update_s` = {addr, tgt}, each `rv64_eaddr_width_gp` wide;
  - localparam `bp_fe_btb_upd_els_gp` = 4.
- No sub-module: flop array, compare vector, pointer and counter logic are all inline.
- One-hot match vector, reduced to an index with `bsg_encode_one_hot`.

## Test plan
- **Idle drain:** reset, then enqueue {0x8000_0010 → 0x8000_0100} with `fe_r_v_i`=0.
  - Next cycle: `btb_w_v_o`=1 with that pair.
  - Following cycle: `btb_w_v_o`=0.
- **Deferral and starvation:** `fe_r_v_i` held at 1, enqueue one entry.
  - No write for 8 cycles.
  - Forced write on the 9th cycle after becoming head.
  - Starve counter returns to 0.
- **Full and backpressure:** `fe_r_v_i`=1, enqueue 4 distinct addresses 0x10, 0x20, 0x30, 0x40.
  - `upd_ready_o`=0.
  - The forced drain writes 0x10 in the same cycle.
  - Ready returns the next cycle.
  - The remaining entries drain in order 0x20, 0x30, 0x40.
- **Coalesce:**
  - Enqueue 0x20→0xA, 0x30→0xB, then 0x20→0xC, all under `fe_r_v_i`=1.
  - Count is 2.
  - Drained sequence: 0x20→0xC, then 0x30→0xB.
- **Head race:**
  - Head is 0x20→0xA and draining; an update 0x20→0xD arrives in the same cycle.
  - Writes observed: 0x20→0xA, then 0x20→0xD.
- **Reset mid-operation:**
  - 3 entries pending, assert `reset_i` for 1 cycle.
  - No `btb_w_v_o` during or after reset.
  - `upd_ready_o`=1 the next cycle; a new enqueue drains normally.
